// File: rtl/avmm_host_initiator_pkg.sv
// Beat formats and widths shared by the host initiator, its interface and the memory model.
package avmm_host_initiator_pkg;
  localparam int DATA_WIDTH = 512;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int TS_WIDTH   = 64;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [51:6]           address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic [DATA_WIDTH-1:0] writedata;
    logic [TS_WIDTH-1:0]   timestamp;
  } avmm_req;

  typedef struct packed {
    logic                  readdatavalid;
    logic [DATA_WIDTH-1:0] readdata;
  } avmm_rsp;

  typedef struct packed {
    logic                  write;
    logic [51:6]           address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic [DATA_WIDTH-1:0] writedata;
  } avmm_cmd;

  // Reads carry no payload, so their byteenable/writedata go out as zero.
  function automatic avmm_req cmd_to_req(input avmm_cmd cmd, input logic [TS_WIDTH-1:0] ts);
    avmm_req req;
    req.read       = ~cmd.write;
    req.write      = cmd.write;
    req.address    = cmd.address;
    req.byteenable = cmd.write ? cmd.byteenable : '0;
    req.writedata  = cmd.write ? cmd.writedata : '0;
    req.timestamp  = ts;
    return req;
  endfunction
endpackage

// File: rtl/avmm_host_initiator_if.sv
// Command, memory and response signals of the host initiator; master is the initiator side.
interface avmm_host_initiator_if #(
  parameter int MAX_OUTSTANDING = 16
) ();
  import avmm_host_initiator_pkg::*;
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [51:6]           cmd_address;
  logic [BE_WIDTH-1:0]   cmd_byteenable;
  logic [DATA_WIDTH-1:0] cmd_writedata;
  avmm_req               mem_req;
  logic                  mem_waitreq;
  avmm_rsp               mem_rsp;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TS_WIDTH-1:0]   rsp_latency;
  logic [OCNT_W-1:0]     outstanding;
  logic                  err_unexp_rsp;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_byteenable, cmd_writedata,
    input  mem_waitreq, mem_rsp,
    output cmd_ready, mem_req, rsp_valid, rsp_data, rsp_latency, outstanding, err_unexp_rsp
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_byteenable, cmd_writedata,
    output mem_waitreq, mem_rsp,
    input  cmd_ready, mem_req, rsp_valid, rsp_data, rsp_latency, outstanding, err_unexp_rsp
  );
endinterface

// File: rtl/avmm_host_initiator_ts_fifo.sv
// Timestamp FIFO for in-flight reads; pointers carry one extra bit to tell full from empty.
module avmm_host_initiator_ts_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/avmm_host_initiator.sv
// Host-side AVMM initiator: one-deep request stage, read credit count, and in-order read
// responses tagged with the round-trip latency measured on a free-running cycle counter.
module avmm_host_initiator #(
  parameter int MAX_OUTSTANDING = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  avmm_host_initiator_if.master bus
);
  import avmm_host_initiator_pkg::*;
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [TS_WIDTH-1:0]   ts_q;
  avmm_req               req_q, req_d;
  logic [OCNT_W-1:0]     ocnt_q, ocnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TS_WIDTH-1:0]   rsp_latency_q, rsp_latency_d;
  logic                  err_q, err_d;

  avmm_cmd             cmd;
  logic                stage_full, drain, accept, accept_rd, rdv, pop;
  logic                fifo_full, fifo_empty;
  logic [TS_WIDTH-1:0] fifo_ts;

  assign cmd        = '{write: bus.cmd_write, address: bus.cmd_address,
                        byteenable: bus.cmd_byteenable, writedata: bus.cmd_writedata};
  assign stage_full = req_q.read | req_q.write;
  assign drain      = stage_full & ~bus.mem_waitreq;
  // The FIFO holds exactly one entry per outstanding read, so full means no credit left.
  assign bus.cmd_ready = (~stage_full | ~bus.mem_waitreq) & (bus.cmd_write | ~fifo_full);
  assign accept     = bus.cmd_valid & bus.cmd_ready;
  assign accept_rd  = accept & ~bus.cmd_write;
  assign rdv        = bus.mem_rsp.readdatavalid;
  assign pop        = rdv & ~fifo_empty;

  avmm_host_initiator_ts_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TS_WIDTH)
  ) u_ts_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept_rd),
    .data_i  (ts_q),
    .pop_i   (pop),
    .data_o  (fifo_ts),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    req_d         = req_q;
    ocnt_d        = ocnt_q;
    rsp_valid_d   = pop;
    rsp_data_d    = rsp_data_q;
    rsp_latency_d = rsp_latency_q;
    err_d         = err_q | (rdv & fifo_empty);

    if (drain) begin
      req_d.read  = 1'b0;
      req_d.write = 1'b0;
    end
    if (accept) req_d = cmd_to_req(cmd, ts_q);

    if (accept_rd && !pop)      ocnt_d = ocnt_q + 1'b1;
    else if (pop && !accept_rd) ocnt_d = ocnt_q - 1'b1;

    if (pop) begin
      rsp_data_d    = bus.mem_rsp.readdata;
      rsp_latency_d = ts_q - fifo_ts;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q          <= '0;
      req_q         <= '0;
      ocnt_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_latency_q <= '0;
      err_q         <= 1'b0;
    end else begin
      ts_q          <= ts_q + 1'b1;
      req_q         <= req_d;
      ocnt_q        <= ocnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_latency_q <= rsp_latency_d;
      err_q         <= err_d;
    end
  end

  assign bus.mem_req       = req_q;
  assign bus.outstanding   = ocnt_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_latency   = rsp_latency_q;
  assign bus.err_unexp_rsp = err_q;
endmodule

// File: tb/tb_avmm_host_initiator.sv
// Bench for avmm_host_initiator: directed scenarios then random traffic against a queue model.
module tb_avmm_host_initiator;
  import avmm_host_initiator_pkg::*;
  localparam int MAXO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avmm_host_initiator_if #(.MAX_OUTSTANDING(MAXO)) ifc ();
  avmm_host_initiator #(.MAX_OUTSTANDING(MAXO)) dut (.clk_i(clk), .rst_i(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  logic        d_valid, d_write, d_waitreq, d_rdv;
  logic [51:6] d_addr;
  logic [63:0] d_be;
  logic [511:0] d_wd, d_rdata;

  // reference model: commands waiting for the bus, accept times of reads, response schedule
  logic [63:0]  m_ts;
  avmm_req      beat_q[$];
  logic [63:0]  lat_q[$];
  logic [63:0]  sched_q[$];
  logic [63:0]  last_due;
  logic         m_err, rsp_due, auto_rsp;
  logic [511:0] exp_data;
  logic [63:0]  exp_lat;

  task automatic chk(input string tag, input logic [687:0] obs, input logic [687:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic new_cmd(input logic wr);
    logic [63:0] a;
    a       = {$urandom, $urandom};
    d_valid = 1'b1;
    d_write = wr;
    d_addr  = a[45:0];
    d_be    = {$urandom, $urandom};
    d_wd    = rand512();
  endtask

  task automatic idle();
    d_valid   = 1'b0;
    d_rdv     = 1'b0;
    d_waitreq = 1'b0;
  endtask

  task automatic drive();
    ifc.cmd_valid              = d_valid;
    ifc.cmd_write              = d_write;
    ifc.cmd_address            = d_addr;
    ifc.cmd_byteenable         = d_be;
    ifc.cmd_writedata          = d_wd;
    ifc.mem_waitreq            = d_waitreq;
    ifc.mem_rsp.readdatavalid  = d_rdv;
    ifc.mem_rsp.readdata       = d_rdata;
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model, cross the rising edge.
  task automatic step();
    logic    ready_exp;
    logic [63:0] due;
    avmm_req b;
    drive();
    #1;
    chk("rsp_valid", 688'(ifc.rsp_valid), 688'(rsp_due));
    if (rsp_due) begin
      chk("rsp_data", 688'(ifc.rsp_data), 688'(exp_data));
      chk("rsp_latency", 688'(ifc.rsp_latency), 688'(exp_lat));
    end
    chk("outstanding", 688'(ifc.outstanding), 688'(lat_q.size()));
    chk("err_unexp_rsp", 688'(ifc.err_unexp_rsp), 688'(m_err));
    ready_exp = (beat_q.size() == 0 || !d_waitreq) && (d_write || lat_q.size() < MAXO);
    chk("cmd_ready", 688'(ifc.cmd_ready), 688'(ready_exp));
    if (beat_q.size() == 0) chk("req_idle", 688'({ifc.mem_req.read, ifc.mem_req.write}), 688'(0));
    else                    chk("mem_req", 688'(ifc.mem_req), 688'(beat_q[0]));

    if (beat_q.size() != 0 && !d_waitreq) begin
      b = beat_q.pop_front();
      if (b.read && auto_rsp) begin
        due = m_ts + 64'd1 + 64'($urandom_range(0, 3));
        if (due <= last_due) due = last_due + 64'd1;
        last_due = due;
        sched_q.push_back(due);
      end
    end
    rsp_due = 1'b0;
    if (d_rdv) begin
      if (lat_q.size() != 0) begin
        exp_lat  = m_ts - lat_q.pop_front();
        exp_data = d_rdata;
        rsp_due  = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (d_valid && ready_exp) begin
      b.read       = !d_write;
      b.write      = d_write;
      b.address    = d_addr;
      b.byteenable = d_write ? d_be : '0;
      b.writedata  = d_write ? d_wd : '0;
      b.timestamp  = m_ts;
      beat_q.push_back(b);
      if (!d_write) lat_q.push_back(m_ts);
    end
    @(posedge clk);
    m_ts = m_ts + 64'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    drive();
    #1;
    chk("rst_mem_req", 688'(ifc.mem_req), 688'(0));
    chk("rst_rsp_valid", 688'(ifc.rsp_valid), 688'(0));
    chk("rst_rsp_data", 688'(ifc.rsp_data), 688'(0));
    chk("rst_rsp_latency", 688'(ifc.rsp_latency), 688'(0));
    chk("rst_outstanding", 688'(ifc.outstanding), 688'(0));
    chk("rst_err", 688'(ifc.err_unexp_rsp), 688'(0));
    beat_q.delete();
    lat_q.delete();
    sched_q.delete();
    last_due = '0;
    m_err    = 1'b0;
    rsp_due  = 1'b0;
    m_ts     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_cycle(input logic allow_cmd);
    d_valid   = allow_cmd && ($urandom_range(0, 2) != 0);
    d_write   = $urandom_range(0, 1) == 1;
    d_addr    = 46'({$urandom, $urandom});
    d_be      = {$urandom, $urandom};
    d_wd      = rand512();
    d_waitreq = $urandom_range(0, 3) == 0;
    d_rdv     = 1'b0;
    if (sched_q.size() != 0 && sched_q[0] <= m_ts) begin
      void'(sched_q.pop_front());
      d_rdv   = 1'b1;
      d_rdata = rand512();
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    avmm_req      wbeat;
    logic [51:6]  rd_addr;
    logic [511:0] rdat;
    d_write  = 1'b0;
    d_addr   = '0;
    d_be     = '0;
    d_wd     = '0;
    d_rdata  = '0;
    auto_rsp = 1'b0;
    idle();
    drive();
    @(negedge clk);
    do_reset();

    // 1: read accepted at ts 10, data back at ts 16, response at ts 17 with latency 6
    while (m_ts < 64'd10) step();
    new_cmd(1'b0);
    step();
    chk("t1_req_read", 688'(ifc.mem_req.read), 688'(1));
    chk("t1_req_ts", 688'(ifc.mem_req.timestamp), 688'(10));
    idle();
    while (m_ts < 64'd16) step();
    d_rdv   = 1'b1;
    d_rdata = rand512();
    rdat    = d_rdata;
    step();
    chk("t1_rsp_valid", 688'(ifc.rsp_valid), 688'(1));
    chk("t1_rsp_latency", 688'(ifc.rsp_latency), 688'(6));
    chk("t1_rsp_data", 688'(ifc.rsp_data), 688'(rdat));
    idle();
    step();

    // 2: credit limit
    do_reset();
    for (int i = 0; i < MAXO; i++) begin
      new_cmd(1'b0);
      step();
    end
    chk("t2_outstanding_full", 688'(ifc.outstanding), 688'(MAXO));
    new_cmd(1'b0);
    step();
    chk("t2_ready_blocked", 688'(ifc.cmd_ready), 688'(0));
    d_rdv   = 1'b1;
    d_rdata = rand512();
    step();
    chk("t2_ready_after_rsp", 688'(ifc.cmd_ready), 688'(1));
    d_rdv = 1'b0;
    step();
    chk("t2_outstanding_refill", 688'(ifc.outstanding), 688'(MAXO));
    idle();
    step();

    // 3: write stalled by waitreq, second command waits, then no bubble
    do_reset();
    new_cmd(1'b1);
    wbeat = '{read: 1'b0, write: 1'b1, address: d_addr, byteenable: d_be,
              writedata: d_wd, timestamp: m_ts};
    step();
    new_cmd(1'b0);
    rd_addr   = d_addr;
    d_waitreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_stall_ready", 688'(ifc.cmd_ready), 688'(0));
      chk("t3_stall_req", 688'(ifc.mem_req), 688'(wbeat));
    end
    d_waitreq = 1'b0;
    step();
    chk("t3_next_read", 688'(ifc.mem_req.read), 688'(1));
    chk("t3_next_write", 688'(ifc.mem_req.write), 688'(0));
    chk("t3_next_addr", 688'(ifc.mem_req.address), 688'(rd_addr));
    idle();
    step();

    // 4: unexpected response
    do_reset();
    d_rdv   = 1'b1;
    d_rdata = rand512();
    step();
    chk("t4_err_set", 688'(ifc.err_unexp_rsp), 688'(1));
    chk("t4_no_rsp", 688'(ifc.rsp_valid), 688'(0));
    idle();
    step();
    step();
    chk("t4_err_sticky", 688'(ifc.err_unexp_rsp), 688'(1));

    // 5: latency across counter wrap
    do_reset();
    step();
    force dut.ts_q = 64'hFFFF_FFFF_FFFF_FFFD;
    m_ts = 64'hFFFF_FFFF_FFFF_FFFD;
    new_cmd(1'b0);
    step();
    chk("t5_req_ts", 688'(ifc.mem_req.timestamp), 688'(64'hFFFF_FFFF_FFFF_FFFD));
    idle();
    step();
    force dut.ts_q = 64'd2;
    m_ts    = 64'd2;
    d_rdv   = 1'b1;
    d_rdata = rand512();
    step();
    chk("t5_rsp_valid", 688'(ifc.rsp_valid), 688'(1));
    chk("t5_rsp_latency", 688'(ifc.rsp_latency), 688'(5));
    idle();
    release dut.ts_q;
    step();

    // 6: reset with reads pending, late response afterwards
    do_reset();
    for (int i = 0; i < 3; i++) begin
      new_cmd(1'b0);
      step();
    end
    idle();
    step();
    chk("t6_pending", 688'(ifc.outstanding), 688'(3));
    #2;
    do_reset();
    d_rdv   = 1'b1;
    d_rdata = rand512();
    step();
    chk("t6_late_err", 688'(ifc.err_unexp_rsp), 688'(1));
    chk("t6_late_outstanding", 688'(ifc.outstanding), 688'(0));
    idle();
    step();

    // random mixed traffic with in-order responses from a bench-side memory
    do_reset();
    auto_rsp = 1'b1;
    for (int i = 0; i < 400; i++) rand_cycle(1'b1);
    for (int i = 0; i < 200 && (sched_q.size() != 0 || beat_q.size() != 0); i++)
      rand_cycle(1'b0);
    idle();
    step();
    step();
    chk("rand_drained", 688'(ifc.outstanding), 688'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
